// File: rtl/riscv_pkg.sv
// riscv_pkg: shared encodings for the multicycle RV32I controller
// Holds opcodes, FSM state codes, ALUOp codes, ALUControl codes and mux select encodings.
package riscv_pkg;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_A     = 2'b10;

    localparam logic [1:0] SRCB_WD   = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps ALUOp and instruction funct fields to ALUControl
// Ports: i_alu_op (add/sub/funct), i_funct3, i_op5 (op[5]), i_funct7b5 -> o_alu_control.
module alu_decoder import riscv_pkg::*; (
    input  aluop_t     i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_alu_control
);
    logic [2:0] w_funct_ctrl;

    // funct7b5 means sub only for R-type; for I-type it is part of the immediate
    always_comb begin
        w_funct_ctrl = (i_funct3 == 3'b000) ? ((i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD) :
                       (i_funct3 == 3'b010) ? ALU_SLT :
                       (i_funct3 == 3'b110) ? ALU_OR  :
                       (i_funct3 == 3'b111) ? ALU_AND : ALU_ADD;
        o_alu_control = (i_alu_op == ALUOP_ADD) ? ALU_ADD :
                        (i_alu_op == ALUOP_SUB) ? ALU_SUB : w_funct_ctrl;
    end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: Moore control FSM sequencing a multicycle RV32I datapath
// Inputs: clk, reset (async, active-high), op/funct3/funct7b5 from IR, Zero from ALU.
// Outputs: ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl selects; IRWrite,
// PCWrite, RegWrite, MemWrite enables; InstrDone pulse; State for debug.
module mc_controller import riscv_pkg::*; (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic [1:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic       AdrSrc,
    output logic [2:0] ALUControl,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       InstrDone,
    output logic [3:0] State
);
    state_t r_state;
    state_t w_next;
    aluop_t w_alu_op;
    logic   w_pc_update;
    logic   w_branch;
    logic   w_ir_write;
    logic   w_reg_write;
    logic   w_mem_write;
    logic   w_done;
    logic   w_legal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    assign w_legal = (op == OP_LW) | (op == OP_SW) | (op == OP_R) |
                     (op == OP_I) | (op == OP_JAL) | (op == OP_BEQ);

    always_comb begin
        w_next      = S_FETCH;
        w_alu_op    = ALUOP_ADD;
        ALUSrcA     = SRCA_PC;
        ALUSrcB     = SRCB_WD;
        ResultSrc   = RES_ALUOUT;
        AdrSrc      = 1'b0;
        w_pc_update = 1'b0;
        w_branch    = 1'b0;
        w_ir_write  = 1'b0;
        w_reg_write = 1'b0;
        w_mem_write = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_next      = S_DECODE;
                ALUSrcB     = SRCB_FOUR;
                ResultSrc   = RES_ALURESULT;
                w_ir_write  = 1'b1;
                w_pc_update = 1'b1;
            end
            S_DECODE: begin
                w_next  = (op == OP_LW || op == OP_SW) ? S_MEMADR :
                          (op == OP_R)   ? S_EXECR :
                          (op == OP_I)   ? S_EXECI :
                          (op == OP_JAL) ? S_JAL   :
                          (op == OP_BEQ) ? S_BEQ   : S_FETCH;
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                // illegal opcodes retire here as no-ops; PC already advanced in FETCH
                w_done  = ~w_legal;
            end
            S_MEMADR: begin
                w_next  = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
                ALUSrcA = SRCA_A;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: begin
                w_next = S_MEMWB;
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc      = 1'b1;
                w_mem_write = 1'b1;
                w_done      = 1'b1;
            end
            S_EXECR: begin
                w_next   = S_ALUWB;
                ALUSrcA  = SRCA_A;
                w_alu_op = ALUOP_FUNCT;
            end
            S_EXECI: begin
                w_next   = S_ALUWB;
                ALUSrcA  = SRCA_A;
                ALUSrcB  = SRCB_IMM;
                w_alu_op = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_reg_write = 1'b1;
                w_done      = 1'b1;
            end
            S_JAL: begin
                w_next      = S_ALUWB;
                ALUSrcA     = SRCA_OLDPC;
                ALUSrcB     = SRCB_FOUR;
                w_pc_update = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA  = SRCA_A;
                w_alu_op = ALUOP_SUB;
                w_branch = 1'b1;
                w_done   = 1'b1;
            end
            default: ;
        endcase
    end

    alu_decoder u_alu_decoder (
        .i_alu_op      (w_alu_op),
        .i_funct3      (funct3),
        .i_op5         (op[5]),
        .i_funct7b5    (funct7b5),
        .o_alu_control (ALUControl)
    );

    assign ImmSrc = (op == OP_SW)  ? IMM_S :
                    (op == OP_BEQ) ? IMM_B :
                    (op == OP_JAL) ? IMM_J : IMM_I;

    // enables are gated by reset so nothing is written while State already reads FETCH
    assign IRWrite   = w_ir_write & ~reset;
    assign PCWrite   = (w_pc_update | (w_branch & Zero)) & ~reset;
    assign RegWrite  = w_reg_write & ~reset;
    assign MemWrite  = w_mem_write & ~reset;
    assign InstrDone = w_done & ~reset;
    assign State     = r_state;
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed and randomized checks of mc_controller against an instruction-level model
module tb_mc_controller;
    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
    logic       AdrSrc;
    logic [2:0] ALUControl;
    logic       IRWrite, PCWrite, RegWrite, MemWrite, InstrDone;
    logic [3:0] State;
    int         checks = 0;
    int         errors = 0;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (Zero),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .AdrSrc     (AdrSrc),
        .ALUControl (ALUControl),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .InstrDone  (InstrDone),
        .State      (State)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JL = 7'b1101111, BQ = 7'b1100011;

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] outs();
        return {ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc, ALUControl,
                IRWrite, PCWrite, RegWrite, MemWrite, InstrDone};
    endfunction

    // Expected output bundle for a given step of an instruction, straight from the control table
    function automatic logic [16:0] model(input int st, input logic [6:0] o, input logic [2:0] f3,
                                          input logic f7, input logic z);
        logic [1:0] imm, sa, sb, rs;
        logic       adr, irw, pcw, rw, mw, dn;
        logic [2:0] alu, fn;
        logic       legal;
        legal = (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == JL) || (o == BQ);
        imm = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
        fn  = (f3 == 3'd0) ? ((o[5] && f7) ? 3'd1 : 3'd0) : (f3 == 3'd2) ? 3'd5 :
              (f3 == 3'd6) ? 3'd3 : (f3 == 3'd7) ? 3'd2 : 3'd0;
        {sa, sb, rs, adr, alu, irw, pcw, rw, mw, dn} = '0;
        case (st)
            0:  begin sb = 2; rs = 2; irw = 1; pcw = 1; end
            1:  begin sa = 1; sb = 1; dn = !legal; end
            2:  begin sa = 2; sb = 1; end
            3:  adr = 1;
            4:  begin rs = 1; rw = 1; dn = 1; end
            5:  begin adr = 1; mw = 1; dn = 1; end
            6:  begin sa = 2; alu = fn; end
            7:  begin rw = 1; dn = 1; end
            8:  begin sa = 2; sb = 1; alu = fn; end
            9:  begin sa = 1; sb = 2; pcw = 1; end
            10: begin sa = 2; alu = 1; pcw = z; dn = 1; end
            default: ;
        endcase
        return {imm, sa, sb, rs, adr, alu, irw, pcw, rw, mw, dn};
    endfunction

    // Runs one instruction from FETCH; zm 0/1 fixes Zero, 2 randomizes it every cycle
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zm, input string tag);
        int q[$];
        q = {0, 1};
        if (o == LW || o == SW) q = {q, 2, (o == LW) ? 3 : 5};
        if (o == LW) q = {q, 4};
        if (o == RT) q = {q, 6, 7};
        if (o == IT) q = {q, 8, 7};
        if (o == JL) q = {q, 9, 7};
        if (o == BQ) q = {q, 10};
        foreach (q[i]) begin
            op = o;
            funct3 = f3;
            funct7b5 = f7;
            Zero = (zm == 2) ? 1'($urandom_range(0, 1)) : (zm == 1);
            #1;
            chk($sformatf("%s state step%0d", tag, i), {13'd0, State}, 17'(q[i]));
            chk($sformatf("%s outputs step%0d", tag, i), outs(), model(q[i], o, f3, f7, Zero));
            @(negedge clk);
        end
    endtask

    initial begin
        logic [6:0] ro;
        reset = 1'b1;
        op = '0;
        funct3 = '0;
        funct7b5 = 1'b0;
        Zero = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("por state", {13'd0, State}, 17'd0);
        chk("por enables", {12'd0, IRWrite, PCWrite, RegWrite, MemWrite, InstrDone}, 17'd0);
        @(negedge clk);
        reset = 1'b0;
        run_instr(LW, 3'd2, 1'b0, 0, "lw");
        op = LW;
        repeat (3) @(negedge clk);
        #1;
        chk("reach memread", {13'd0, State}, 17'd3);
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst state c%0d", i), {13'd0, State}, 17'd0);
            chk($sformatf("rst enables c%0d", i),
                {12'd0, IRWrite, PCWrite, RegWrite, MemWrite, InstrDone}, 17'd0);
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        reset = 1'b0;
        run_instr(SW, 3'd2, 1'b0, 0, "sw");
        run_instr(RT, 3'd0, 1'b1, 0, "sub");
        run_instr(RT, 3'd0, 1'b0, 0, "add");
        run_instr(RT, 3'd2, 1'b0, 0, "slt");
        run_instr(IT, 3'd0, 1'b1, 0, "addi");
        run_instr(BQ, 3'd0, 1'b0, 1, "beq taken");
        run_instr(BQ, 3'd0, 1'b0, 0, "beq not");
        run_instr(JL, 3'd0, 1'b0, 0, "jal");
        run_instr(7'b1111111, 3'd0, 1'b0, 0, "illegal");
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0: ro = LW;
                1: ro = SW;
                2: ro = RT;
                3: ro = IT;
                4: ro = JL;
                5: ro = BQ;
                default: ro = 7'($urandom);
            endcase
            run_instr(ro, 3'($urandom), 1'($urandom), 2, $sformatf("rnd%0d op%b", n, ro));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Moore-style control FSM that sequences a multicycle RV32I datapath built from the existing primitives: PC register, shared instruction/data memory, IR, OldPC, A/WriteData, ALUOut and Data registers.
- Consumes opcode/funct fields from the IR and the ALU Zero flag.
- Issues per-state mux selects, register enables and ALUControl.
- Supports lw, sw, R-type ALU, I-type ALU, beq and jal.

Parameters:
- none (all encodings are fixed in the shared package)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces the FSM to Fetch
- op  in  7  Instr[6:0] from IR
- funct3  in  3  Instr[14:12]
- funct7b5  in  1  Instr[30]
- Zero  in  1  ALU zero flag, same cycle
- ImmSrc  out  2  00 I, 01 S, 10 B, 11 J
- ALUSrcA  out  2  00 PC, 01 OldPC, 10 A register
- ALUSrcB  out  2  00 WriteData register, 01 ImmExt, 10 constant 4
- ResultSrc  out  2  00 ALUOut, 01 Data, 10 ALUResult
- AdrSrc  out  1  memory address: 0 PC, 1 Result
- ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- IRWrite  out  1  IR/OldPC load enable
- PCWrite  out  1  PC load enable
- RegWrite  out  1  register file write enable
- MemWrite  out  1  memory write enable
- InstrDone  out  1  one-cycle pulse in the final state of each instruction
- State  out  4  current state, for debug/verification

Behaviour:
- State register: 4 bits, async reset to FETCH (0). Encodings are FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, ALUWB 7, EXECI 8, JAL 9, BEQ 10. Codes 11–15 transition to FETCH and drive all enables low.
- Transitions:
  - FETCH → DECODE.
  - DECODE by op:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECR
    - 0010011 → EXECI
    - 1101111 → JAL
    - 1100011 → BEQ
    - any other op → FETCH (illegal instruction is a no-op; PC already advanced)
  - MEMADR: op=0000011 → MEMREAD, else → MEMWRITE.
  - MEMREAD → MEMWB → FETCH. MEMWRITE → FETCH.
  - EXECR → ALUWB. EXECI → ALUWB. JAL → ALUWB. ALUWB → FETCH.
  - BEQ → FETCH.
- Cycle counts: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- Per-state outputs (unlisted signals are 0 / 00):
  - FETCH: AdrSrc 0, IRWrite 1, ALUSrcA 00, ALUSrcB 10, ALUOp add, ResultSrc 10, PCUpdate 1.
  - DECODE: ALUSrcA 01, ALUSrcB 01, ALUOp add (branch target into ALUOut).
  - MEMADR: ALUSrcA 10, ALUSrcB 01, ALUOp add.
  - MEMREAD: ResultSrc 00, AdrSrc 1.
  - MEMWB: ResultSrc 01, RegWrite 1.
  - MEMWRITE: ResultSrc 00, AdrSrc 1, MemWrite 1.
  - EXECR: ALUSrcA 10, ALUSrcB 00, ALUOp funct.
  - EXECI: ALUSrcA 10, ALUSrcB 01, ALUOp funct.
  - ALUWB: ResultSrc 00, RegWrite 1.
  - JAL: ALUSrcA 01, ALUSrcB 10, ALUOp add, ResultSrc 00, PCUpdate 1.
  - BEQ: ALUSrcA 10, ALUSrcB 00, ALUOp sub, ResultSrc 00, Branch 1.
- PCWrite = PCUpdate | (Branch & Zero). This is the only Mealy term; Zero is sampled in the same cycle.
- InstrDone = 1 in MEMWB, MEMWRITE, ALUWB, BEQ, and in DECODE when op is illegal.
- ImmSrc is decoded from op combinationally, independent of state: lw/I-ALU 00, sw 01, beq 10, jal 11, other 00.
- ALUControl:
  - ALUOp add → 000; ALUOp sub → 001.
  - ALUOp funct, by funct3:
    - 000 → 001 if (op[5] & funct7b5), else 000
    - 010 → 101
    - 110 → 011
    - 111 → 010
    - other → 000
- While reset is high, IRWrite, PCWrite, RegWrite, MemWrite and InstrDone are forced to 0, even though State reads FETCH.
- Reset asserted mid-instruction abandons it with no further writes. First FETCH enables appear in the first cycle after reset deasserts.

Decomposition:
- riscv_pkg holds: opcode constants, state encodings, ALUOp codes (add/sub/funct), ALUControl codes, and ImmSrc/ResultSrc/ALUSrcA/ALUSrcB encodings.
- One sub-module, alu_decoder (combinational): ALUOp, funct3, op[5], funct7b5 → ALUControl.
- mc_controller keeps the state register, next-state logic, output decode and ImmSrc decode.

Test Plan:
- Reset held 3 cycles mid-MEMREAD, then released → State=0 during reset with all write enables 0. The next cycle shows IRWrite=1, PCWrite=1, ALUSrcB=10, ResultSrc=10.
- op=0000011 (lw) → States 0,1,2,3,4,0. RegWrite=1 only in state 4, ResultSrc=01. InstrDone pulses once. ImmSrc=00 throughout.
- op=0100011 (sw) → States 0,1,2,5,0. MemWrite=1 only in state 5 with AdrSrc=1. ImmSrc=01.
- op=0110011, funct3=000, funct7b5=1 → EXECR drives ALUControl=001. Repeat with funct7b5=0 → 000. Repeat with funct3=010 → 101. RegWrite=1 in ALUWB.
- op=1100011 (beq) → in BEQ, Zero=1 gives PCWrite=1 and Zero=0 gives PCWrite=0. ALUControl=001 and ImmSrc=10 in both cases. Total 3 cycles.
- op=1101111 (jal) → JAL state has PCWrite=1, ALUSrcA=01, ALUSrcB=10, ImmSrc=11, followed by ALUWB. op=1111111 → DECODE goes to FETCH with InstrDone=1 and no write enables.
